prbs4_checker: RTL and testbench



---
 rtl/prbs4_checker.sv | 156 +++++++++++++++
 tb/tb_prbs4_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prbs4_checker.sv
// PRBS4 checker: aligns to a sync word, predicts the 4-bit LFSR stream and counts matches/mismatches.
// Optional build macro PRBS4_CHK_SELFSEED_EN: any nonzero valid sample seeds the predictor in HUNT.
module prbs4_checker #(
  parameter logic [3:0] ALIGN_WORD = 4'hD,
  parameter int         LOCK_CNT   = 4,
  parameter int         LOSS_CNT   = 3,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [3:0]       data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] good_count,
  output logic             zero_seen
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [3:0] lfsr_next(input logic [3:0] d);
    return {d[2], d[1], d[0] ^ d[3], d[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       expected_q, expected_d;
  logic [3:0]       match_run_q, match_run_d;
  logic [3:0]       miss_run_q, miss_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] good_count_q, good_count_d;
  logic             zero_seen_q, zero_seen_d;

  logic       seed_ok;
  logic       err_inc;
  logic       good_inc;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

`ifdef PRBS4_CHK_SELFSEED_EN
  assign seed_ok = (data != 4'h0);
`else
  assign seed_ok = (data == ALIGN_WORD);
`endif

  assign match_inc = match_run_q + 4'd1;
  assign miss_inc  = miss_run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    good_inc    = 1'b0;
    zero_seen_d = zero_seen_q;

    if (valid) begin
      if (data == 4'h0) zero_seen_d = 1'b1;
      case (state_q)
        HUNT: begin
          if (seed_ok) begin
            expected_d  = lfsr_next(data);
            state_d     = VERIFY;
            match_run_d = 4'd0;
            miss_run_d  = 4'd0;
          end
        end
        VERIFY, LOCKED: begin
          if (data == expected_q) begin
            expected_d = lfsr_next(expected_q);
            good_inc   = 1'b1;
            miss_run_d = 4'd0;
            if (state_q == VERIFY) begin
              match_run_d = match_inc;
              if (match_inc == LOCK_N) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            match_run_d = 4'd0;
            miss_run_d  = miss_inc;
            // An all-zero word is the LFSR lockup value and cannot resync the
            // predictor, so step the prediction past it instead.
            expected_d  = (data == 4'h0) ? lfsr_next(expected_q) : lfsr_next(data);
            if (miss_inc == LOSS_N) begin
              state_d    = HUNT;
              locked_d   = 1'b0;
              miss_run_d = 4'd0;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end

    if (clear) begin
      err_count_d  = '0;
      good_count_d = '0;
      zero_seen_d  = 1'b0;
    end else begin
      err_count_d  = err_inc  ? sat_inc(err_count_q)  : err_count_q;
      good_count_d = good_inc ? sat_inc(good_count_q) : good_count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      expected_q   <= 4'h0;
      match_run_q  <= 4'd0;
      miss_run_q   <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      good_count_q <= '0;
      zero_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_run_q  <= match_run_d;
      miss_run_q   <= miss_run_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      good_count_q <= good_count_d;
      zero_seen_q  <= zero_seen_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign good_count = good_count_q;
  assign zero_seen  = zero_seen_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker (default build, CNT_W=4): vector table plus hand sequences feeding a scoreboard.
module tb_prbs4_checker;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [3:0] SEQ [15] = '{4'hF, 4'hD, 4'h9, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                      4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid = 1'b0;
  logic [3:0] data = 4'h0;
  logic clear = 1'b0;
  logic locked, err_pulse, zero_seen;
  logic [CNT_W-1:0] err_count, good_count;

  prbs4_checker #(.ALIGN_WORD(4'hD), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .good_count(good_count), .zero_seen(zero_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [3:0] d; logic clr; logic lk; logic er; logic gd;
  } vec_t;
  typedef struct {
    logic lk; logic er; logic [CNT_W-1:0] ec; logic [CNT_W-1:0] gc; logic zs;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] m_err = '0;
  logic [CNT_W-1:0] m_good = '0;
  logic m_zero = 1'b0;

  function automatic logic [3:0] nxt(input logic [3:0] x);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 15; i++)
      if (SEQ[i] == x) r = SEQ[(i + 1) % 15];
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic [3:0] d, input logic clr,
                              input logic lk, input logic er, input logic gd);
    vec_t t;
    t.v = v; t.d = d; t.clr = clr; t.lk = lk; t.er = er; t.gd = gd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic clr,
                       input logic lk, input logic er, input logic gd);
    exp_t e;
    @(negedge clk);
    valid = v; data = d; clear = clr;
    if (clr) begin
      m_err = '0; m_good = '0; m_zero = 1'b0;
    end else begin
      if (er && m_err != CMAX) m_err = m_err + 1'b1;
      if (gd && m_good != CMAX) m_good = m_good + 1'b1;
      if (v && d == 4'h0) m_zero = 1'b1;
    end
    e.lk = lk; e.er = er; e.ec = m_err; e.gc = m_good; e.zs = m_zero;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("locked", 32'(locked), 32'(e.lk));
      chk("err_pulse", 32'(err_pulse), 32'(e.er));
      chk("err_count", 32'(err_count), 32'(e.ec));
      chk("good_count", 32'(good_count), 32'(e.gc));
      chk("zero_seen", 32'(zero_seen), 32'(e.zs));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_good_count"}, 32'(good_count), 32'd0);
    chk({tag, "_zero_seen"}, 32'(zero_seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pr;
    logic [3:0] dw;

    // Clean lock, zero substitution, valid gating, loss of lock, re-hunt, relock, clear.
    tbl.push_back(mk(1, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hD, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h9, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h2, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h4, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'h0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'h3, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'h6, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'hC, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'hC, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'hB, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'hB, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'h5, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'h5, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'h1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'h7, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'h3, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'h6, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hC, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h9, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hD, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h9, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h5, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'hA, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h7, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'hE, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'hF, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'hD, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'h9, 1, 1, 0, 1));

    repeat (5) @(posedge clk);
    #2;
    check_all_zero("reset");
    repeat (5) @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) drive(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].lk, tbl[i].er, tbl[i].gd);

    // Twenty mismatches in pairs, each pair followed by a resynchronised match.
    pr = 4'h1;
    for (int k = 0; k < 10; k++) begin
      dw = (pr == 4'h6) ? 4'h3 : 4'h6;
      drive(1, dw, 0, 1, 1, 0); pr = nxt(dw);
      dw = (pr == 4'h6) ? 4'h3 : 4'h6;
      drive(1, dw, 0, 1, 1, 0); pr = nxt(dw);
      drive(1, pr, 0, 1, 0, 1); pr = nxt(pr);
    end

    // Clear together with a mismatch, then lose lock and re-enter VERIFY.
    dw = (pr == 4'h6) ? 4'h3 : 4'h6;
    drive(1, dw, 1, 1, 1, 0); pr = nxt(dw);
    dw = (pr == 4'h6) ? 4'h3 : 4'h6;
    drive(1, dw, 0, 1, 1, 0); pr = nxt(dw);
    dw = (pr == 4'h6) ? 4'h3 : 4'h6;
    drive(1, dw, 0, 0, 1, 0);
    drive(1, 4'h0, 0, 0, 0, 0);
    drive(1, 4'hD, 0, 0, 0, 0);
    drive(1, 4'h9, 0, 0, 0, 1);
    @(negedge clk);
    valid = 1'b0;

    // Asynchronous reset between edges while in VERIFY.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_err = '0; m_good = '0; m_zero = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    drive(1, 4'h9, 0, 0, 0, 0);
    drive(1, 4'hD, 0, 0, 0, 0);
    drive(1, 4'h9, 0, 0, 0, 1);
    drive(1, 4'h1, 0, 0, 0, 1);
    drive(1, 4'h2, 0, 0, 0, 1);
    drive(1, 4'h4, 0, 1, 0, 1);
    drive(1, 4'h8, 0, 1, 0, 1);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
